// File: rtl/branch_resolve_pipe_if.sv
// Branch resolution handshake bundle.
// Carries the input branch request (valid/ready plus funct3, operands, PC,
// immediate and predicted direction) and the resolved result (valid/ready
// plus taken, mispredict, illegal and redirect PC).
//   master : producer of branch requests / consumer of results
//   slave  : the resolution unit
interface branch_resolve_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic            out_mispredict;
  logic            out_illegal;
  logic [XLEN-1:0] out_redirect_pc;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken,
    output out_ready,
    input  in_ready,
    input  out_valid, out_taken, out_mispredict, out_illegal, out_redirect_pc
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken,
    input  out_ready,
    output in_ready,
    output out_valid, out_taken, out_mispredict, out_illegal, out_redirect_pc
  );
endinterface

// File: rtl/branch_resolve_pipe.sv
// Pipelined conditional-branch resolution unit.
// Resolves a branch in stage 0 (compare, taken, redirect target) and carries
// the result through STAGES registered stages with bubble-collapsing
// valid/ready flow control. Also keeps saturating counts of completed legal
// branches and mispredicts.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          kills every in-flight entry at the clock edge
//   clr_counts     synchronous clear of both counters (beats increments)
//   bus            branch request / result handshake (slave side)
//   br_count       completed legal branches (saturating)
//   mispred_count  completed mispredicted branches (saturating)
module branch_resolve_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 clr_counts,
  branch_resolve_pipe_if.slave bus,
  output logic [CNT_W-1:0]     br_count,
  output logic [CNT_W-1:0]     mispred_count
);

  typedef struct packed {
    logic            taken;
    logic            mispredict;
    logic            illegal;
    logic [XLEN-1:0] redirect;
  } entry_t;

  localparam int LAST = STAGES - 1;

  // Returns {illegal, taken} for a branch funct3 and its two operands.
  function automatic logic [1:0] resolve(input logic [2:0]      f3,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    logic eq;
    logic lt;
    logic ltu;
    logic [1:0] res;
    eq  = (a == b);
    lt  = ($signed(a) < $signed(b));
    ltu = (a < b);
    case (f3)
      3'b000:  res = {1'b0, eq};
      3'b001:  res = {1'b0, !eq};
      3'b100:  res = {1'b0, lt};
      3'b101:  res = {1'b0, !lt};
      3'b110:  res = {1'b0, ltu};
      3'b111:  res = {1'b0, !ltu};
      default: res = {1'b1, 1'b0};
    endcase
    return res;
  endfunction

  logic [STAGES-1:0] vld_r;
  entry_t            stage_r   [STAGES];
  entry_t            src_ent_s [STAGES];
  logic [STAGES-1:0] src_vld_s;
  logic [STAGES-1:0] load_s;
  entry_t            new_ent_s;
  logic [1:0]        res_s;
  logic [XLEN-1:0]   pc_seq_s;
  logic [XLEN-1:0]   pc_tgt_s;
  logic              out_xfer_s;

  // Resolve the incoming branch; both sums wrap modulo 2^XLEN.
  always_comb begin
    res_s                = resolve(bus.in_funct3, bus.in_rs1, bus.in_rs2);
    pc_seq_s             = bus.in_pc + XLEN'(3'd4);
    pc_tgt_s             = bus.in_pc + bus.in_imm;
    new_ent_s.illegal    = res_s[1];
    new_ent_s.taken      = res_s[0];
    new_ent_s.mispredict = !res_s[1] && (res_s[0] != bus.in_pred_taken);
    new_ent_s.redirect   = res_s[0] ? pc_tgt_s : pc_seq_s;
  end

  // Load enables: a stage loads when empty or when the stage after it loads
  // (the consumer, for the last stage); walked from the output backwards.
  always_comb begin
    logic chain;
    chain  = bus.out_ready;
    load_s = '0;
    for (int k = LAST; k >= 0; k--) begin
      chain     = !vld_r[k] || chain;
      load_s[k] = chain;
    end
  end

  // Source of each stage: the resolver for stage 0, the previous stage otherwise.
  always_comb begin
    src_vld_s[0] = bus.in_valid;
    src_ent_s[0] = new_ent_s;
    for (int k = 1; k < STAGES; k++) begin
      src_vld_s[k] = vld_r[k-1];
      src_ent_s[k] = stage_r[k-1];
    end
  end

  // Pipeline stage registers; payload only moves when a real entry moves so
  // a stalled or drained output keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          vld_r[k] <= 1'b0;
        end else if (load_s[k]) begin
          vld_r[k] <= src_vld_s[k];
        end
        if (load_s[k] && src_vld_s[k]) begin
          stage_r[k] <= src_ent_s[k];
        end
      end
    end
  end

  assign out_xfer_s = vld_r[LAST] && bus.out_ready;

  // Saturating performance counters, clear takes priority over the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (clr_counts) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (out_xfer_s) begin
      if (!stage_r[LAST].illegal && (br_count != '1)) begin
        br_count <= br_count + CNT_W'(1'b1);
      end
      if (stage_r[LAST].mispredict && (mispred_count != '1)) begin
        mispred_count <= mispred_count + CNT_W'(1'b1);
      end
    end
  end

  assign bus.in_ready        = load_s[0];
  assign bus.out_valid       = vld_r[LAST];
  assign bus.out_taken       = stage_r[LAST].taken;
  assign bus.out_mispredict  = stage_r[LAST].mispredict;
  assign bus.out_illegal     = stage_r[LAST].illegal;
  assign bus.out_redirect_pc = stage_r[LAST].redirect;

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Self-checking bench for branch_resolve_pipe (STAGES=2, CNT_W=4).
// A queue-based reference model tracks each accepted branch and its position
// in the pipe; every cycle it predicts in_ready, out_valid, the result fields
// and the counters. Hand-computed vectors and directed sequences cover the
// corner cases; a randomized phase exercises flow control, flush and clear.
module tb_branch_resolve_pipe;
  localparam int XL   = 32;
  localparam int S    = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          clr_counts;
  logic [CW-1:0] br_count;
  logic [CW-1:0] mispred_count;

  branch_resolve_pipe_if #(.XLEN(XL)) bus();

  branch_resolve_pipe #(.XLEN(XL), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_counts(clr_counts),
    .bus(bus), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        taken;
    logic        mis;
    logic        ill;
    logic [31:0] redir;
    int          pos;
  } ment_t;

  ment_t q[$];
  int    mbr = 0;
  int    mmp = 0;

  function automatic ment_t ref_entry(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] pc,
                                      input logic [31:0] imm, input logic pred);
    ment_t e;
    logic  t;
    t     = 1'b0;
    e.ill = 1'b0;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = ($signed(a) < $signed(b));
      3'b101:  t = ($signed(a) >= $signed(b));
      3'b110:  t = (a < b);
      3'b111:  t = (a >= b);
      default: e.ill = 1'b1;
    endcase
    e.taken = t;
    e.mis   = !e.ill && (t != pred);
    e.redir = t ? (pc + imm) : (pc + 32'd4);
    e.pos   = 0;
    return e;
  endfunction

  // Compare the DUT against the model for the current cycle, then advance the
  // model across the coming clock edge using the inputs now being driven.
  task automatic model_step();
    logic  exp_ov;
    logic  exp_ir;
    logic  leave;
    int    lim;
    ment_t e;
    exp_ov = (q.size() > 0) && (q[0].pos == S - 1);
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk("out_taken", 64'(bus.out_taken), 64'(q[0].taken));
      chk("out_mispredict", 64'(bus.out_mispredict), 64'(q[0].mis));
      chk("out_illegal", 64'(bus.out_illegal), 64'(q[0].ill));
      chk("out_redirect_pc", 64'(bus.out_redirect_pc), 64'(q[0].redir));
    end
    chk("br_count", 64'(br_count), 64'(mbr));
    chk("mispred_count", 64'(mispred_count), 64'(mmp));
    leave = exp_ov && bus.out_ready;
    lim   = S;
    foreach (q[i]) begin
      if (i == 0 && leave) begin
        lim = S;
      end else if (q[i].pos + 1 < lim) begin
        q[i].pos = q[i].pos + 1;
        lim      = q[i].pos;
      end else begin
        lim = q[i].pos;
      end
    end
    if (leave) begin
      e = q.pop_front();
      if (!e.ill && mbr < CMAX) mbr++;
      if (e.mis && mmp < CMAX) mmp++;
    end
    exp_ir = (q.size() == 0) || (q[q.size()-1].pos != 0);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
    if (clr_counts) begin
      mbr = 0;
      mmp = 0;
    end
    if (flush) begin
      q.delete();
    end else if (bus.in_valid && exp_ir) begin
      q.push_back(ref_entry(bus.in_funct3, bus.in_rs1, bus.in_rs2, bus.in_pc,
                            bus.in_imm, bus.in_pred_taken));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pred);
    bus.in_valid      = v;
    bus.in_funct3     = f3;
    bus.in_rs1        = a;
    bus.in_rs2        = b;
    bus.in_pc         = pc;
    bus.in_imm        = imm;
    bus.in_pred_taken = pred;
  endtask

  task automatic ctl(input logic ordy, input logic fl, input logic clr);
    bus.out_ready = ordy;
    flush         = fl;
    clr_counts    = clr;
  endtask

  task automatic drive_rand(input logic v);
    logic [31:0] a;
    a = $urandom;
    drive(v, 3'($urandom_range(7, 0)), a, ($urandom_range(3, 0) == 0) ? a : 32'($urandom),
          32'($urandom), 32'($urandom), 1'($urandom_range(1, 0)));
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        taken;
    logic        mis;
    logic        ill;
    logic [31:0] redir;
  } vec_t;

  vec_t vecs[12];

  // Send one vector into an empty pipe and check its result after S cycles.
  task automatic apply_vec(input vec_t v, input int idx);
    drive(1'b1, v.f3, v.rs1, v.rs2, v.pc, v.imm, v.pred);
    ctl(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (S - 1) tick();
    @(negedge clk);
    chk($sformatf("vec%0d valid", idx), 64'(bus.out_valid), 64'(1'b1));
    chk($sformatf("vec%0d taken", idx), 64'(bus.out_taken), 64'(v.taken));
    chk($sformatf("vec%0d mispredict", idx), 64'(bus.out_mispredict), 64'(v.mis));
    chk($sformatf("vec%0d illegal", idx), 64'(bus.out_illegal), 64'(v.ill));
    chk($sformatf("vec%0d redirect", idx), 64'(bus.out_redirect_pc), 64'(v.redir));
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_ov;
    int acc;
    vecs[0]  = '{3'b000, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 32'h240};
    vecs[1]  = '{3'b001, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204};
    vecs[2]  = '{3'b010, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h204};
    vecs[3]  = '{3'b011, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'h204};
    vecs[4]  = '{3'b100, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204};
    vecs[5]  = '{3'b101, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 32'h240};
    vecs[6]  = '{3'b110, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 32'h204};
    vecs[7]  = '{3'b111, 32'd5, 32'd5, 32'h200, 32'h40, 1'b0, 1'b1, 1'b1, 1'b0, 32'h240};
    vecs[8]  = '{3'b100, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 32'h120};
    vecs[9]  = '{3'b110, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h104};
    vecs[10] = '{3'b000, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10};
    vecs[11] = '{3'b101, 32'hFFFFFFFD, 32'd2, 32'h300, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0, 32'h304};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    ctl(1'b1, 1'b0, 1'b0);
    #12;
    chk("rst out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("rst out_taken", 64'(bus.out_taken), 64'(1'b0));
    chk("rst out_mispredict", 64'(bus.out_mispredict), 64'(1'b0));
    chk("rst out_illegal", 64'(bus.out_illegal), 64'(1'b0));
    chk("rst out_redirect_pc", 64'(bus.out_redirect_pc), 64'(32'd0));
    chk("rst br_count", 64'(br_count), 64'(4'd0));
    chk("rst mispred_count", 64'(mispred_count), 64'(4'd0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode table: all eight funct3 codes with equal operands
    ctl(1'b1, 1'b0, 1'b1);
    tick();
    ctl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);
    chk("table br_count", 64'(br_count), 64'(4'd6));
    chk("table mispred_count", 64'(mispred_count), 64'(4'd3));
    for (int i = 8; i < 12; i++) apply_vec(vecs[i], i);

    // Back-to-back stream of 8
    ctl(1'b1, 1'b0, 1'b0);
    n_ov = 0;
    for (int i = 0; i < 12; i++) begin
      drive_rand(i < 8);
      tick();
      if (bus.out_valid) n_ov++;
    end
    chk("stream result count", 64'(n_ov), 64'(8));

    // Backpressure: only S entries accepted while the consumer stalls
    ctl(1'b0, 1'b0, 1'b0);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      if (bus.in_ready) acc++;
      tick();
    end
    chk("stall accepted", 64'(acc), 64'(S));
    drive_rand(1'b0);
    ctl(1'b1, 1'b0, 1'b0);
    repeat (S + 2) tick();

    // Flush with two in flight, a new input and a coincident output transfer
    ctl(1'b1, 1'b0, 1'b1);
    tick();
    ctl(1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 32'd7, 32'd7, 32'h400, 32'h8, 1'b0);
    tick();
    drive(1'b1, 3'b001, 32'd7, 32'd9, 32'h404, 32'h8, 1'b0);
    tick();
    drive(1'b1, 3'b001, 32'd1, 32'd2, 32'h408, 32'h8, 1'b0);
    ctl(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    ctl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("flush no out_valid", 64'(bus.out_valid), 64'(1'b0));
      tick();
    end
    chk("flush br_count", 64'(br_count), 64'(4'd1));
    chk("flush mispred_count", 64'(mispred_count), 64'(4'd1));

    // Saturation: 17 mispredicted transfers
    ctl(1'b1, 1'b0, 1'b1);
    tick();
    ctl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 3'b000, 32'd3, 32'd3, 32'h500, 32'h10, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (S + 1) tick();
    chk("sat mispred_count", 64'(mispred_count), 64'(4'd15));
    chk("sat br_count", 64'(br_count), 64'(4'd15));

    // Clear coincident with a transfer drops the event
    drive(1'b1, 3'b000, 32'd3, 32'd3, 32'h600, 32'h10, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (S - 1) tick();
    chk("clr pre out_valid", 64'(bus.out_valid), 64'(1'b1));
    ctl(1'b1, 1'b0, 1'b1);
    tick();
    ctl(1'b1, 1'b0, 1'b0);
    tick();
    chk("clr br_count", 64'(br_count), 64'(4'd0));
    chk("clr mispred_count", 64'(mispred_count), 64'(4'd0));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive_rand($urandom_range(3, 0) != 0);
      ctl($urandom_range(9, 0) < 7, $urandom_range(39, 0) == 0, $urandom_range(59, 0) == 0);
      tick();
    end

    // Reset dropped mid-stream clears outputs immediately
    ctl(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b000, 32'd1, 32'd1, 32'h700, 32'h30, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("pre-reset out_valid", 64'(bus.out_valid), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("async rst out_taken", 64'(bus.out_taken), 64'(1'b0));
    chk("async rst out_mispredict", 64'(bus.out_mispredict), 64'(1'b0));
    chk("async rst out_redirect_pc", 64'(bus.out_redirect_pc), 64'(32'd0));
    chk("async rst br_count", 64'(br_count), 64'(4'd0));
    chk("async rst mispred_count", 64'(mispred_count), 64'(4'd0));
    q.delete();
    mbr = 0;
    mmp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
